// File: rtl/dsp_cfg_regfile_pkg.sv
// Shared constants and helpers for the DSP configuration register file.
package dsp_cfg_pkg;

  // CTRL register (write side) bit positions
  localparam int COMMIT_BIT = 0;

  // STATUS register (read side) bit positions
  localparam int STS_PEND = 0;
  localparam int STS_BUSY = 1;

  // Response buffer occupancy
  typedef enum logic {
    RSP_EMPTY = 1'b0,
    RSP_FULL  = 1'b1
  } rsp_state_t;

  // Number of byte strobes for a register of width dw
  function automatic int strb_width(int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/dsp_cfg_regfile_if.sv
// CPU command/response channel of the configuration register file.
interface dsp_cfg_regfile_if #(
  parameter int DW = 16,
  parameter int AW = 6
);
  logic            cmd_valid;
  logic            cmd_ready;
  logic            cmd_write;
  logic [AW-1:0]   cmd_addr;
  logic [DW-1:0]   cmd_wdata;
  logic [DW/8-1:0] cmd_wstrb;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dsp_cfg_regfile_slot.sv
// One configuration slot: byte-strobed shadow register plus active copy
// that is loaded from shadow on commit.
module dsp_cfg_slot
  import dsp_cfg_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      we_i,
  input  logic [strb_width(DW)-1:0] wstrb_i,
  input  logic [DW-1:0]             wdata_i,
  input  logic                      commit_i,
  output logic [DW-1:0]             shadow_o,
  output logic [DW-1:0]             active_o
);
  localparam int SW = strb_width(DW);

  logic [DW-1:0] shadow_q, shadow_d;
  logic [DW-1:0] active_q;

  // Byte-merge the write data into the shadow value
  always_comb begin
    shadow_d = shadow_q;
    if (we_i) begin
      for (int unsigned b = 0; b < SW; b++) begin
        if (wstrb_i[b]) shadow_d[8*b +: 8] = wdata_i[8*b +: 8];
      end
    end
  end

  // Active copies the pre-write shadow, so a same-cycle write lands in shadow only
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      shadow_q <= shadow_d;
      if (commit_i) active_q <= shadow_q;
    end
  end

  assign shadow_o = shadow_q;
  assign active_o = active_q;

endmodule

// File: rtl/dsp_cfg_regfile.sv
// Configuration register file: indexed shadow/active slots, CTRL/STATUS
// register at index NREG, single-entry response buffer, busy-gated commit.
module dsp_cfg_regfile
  import dsp_cfg_pkg::*;
#(
  parameter int DW   = 16,
  parameter int NREG = 37,
  parameter int AW   = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  dsp_cfg_regfile_if.slave     bus,
  input  logic                 eng_busy,
  output logic                 commit_pend,
  output logic                 commit_done,
  output logic [NREG*DW-1:0]   cfg_flat
);
  localparam logic [AW-1:0] CTRL_ADDR = AW'(NREG);

  rsp_state_t    state_q, state_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          pend_q, pend_d;
  logic          done_q;

  logic            accept;
  logic            addr_ctrl;
  logic            addr_bad;
  logic            do_commit;
  logic            commit_req;
  logic [DW-1:0]   rd_mux;
  logic [NREG-1:0] slot_we;
  logic [DW-1:0]   shadow [NREG];
  logic [DW-1:0]   active [NREG];

  assign bus.cmd_ready = ~reset & ((state_q == RSP_EMPTY) | bus.rsp_ready);
  assign accept        = bus.cmd_valid & bus.cmd_ready;
  assign addr_ctrl     = (bus.cmd_addr == CTRL_ADDR);
  assign addr_bad      = (bus.cmd_addr > CTRL_ADDR);
  assign do_commit     = pend_q & ~eng_busy;
  assign commit_req    = accept & bus.cmd_write & addr_ctrl
                       & bus.cmd_wstrb[COMMIT_BIT] & bus.cmd_wdata[COMMIT_BIT];

  // Address decode: read mux over shadow/STATUS and per-slot write enables
  always_comb begin
    rd_mux  = '0;
    slot_we = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (bus.cmd_addr == AW'(i)) begin
        rd_mux     = shadow[i];
        slot_we[i] = accept & bus.cmd_write;
      end
    end
    if (addr_ctrl) begin
      rd_mux[STS_PEND] = pend_q;
      rd_mux[STS_BUSY] = eng_busy;
    end
  end

  // Response buffer next state; reloads directly when popped and refilled together
  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      RSP_EMPTY: if (accept) state_d = RSP_FULL;
      RSP_FULL:  if (bus.rsp_ready && !accept) state_d = RSP_EMPTY;
      default:   state_d = RSP_EMPTY;
    endcase
    if (accept) begin
      rdata_d = bus.cmd_write ? '0 : rd_mux;
      err_d   = addr_bad;
    end
  end

  // Commit request: a request arriving in the commit cycle re-arms pend
  always_comb begin
    pend_d = (pend_q & ~do_commit) | commit_req;
  end

  // Response buffer and commit state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RSP_EMPTY;
      rdata_q <= '0;
      err_q   <= 1'b0;
      pend_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      pend_q  <= pend_d;
      done_q  <= do_commit;
    end
  end

  for (genvar g = 0; g < NREG; g++) begin : g_slot
    dsp_cfg_slot #(.DW(DW)) u_slot (
      .clk      (clk),
      .reset    (reset),
      .we_i     (slot_we[g]),
      .wstrb_i  (bus.cmd_wstrb),
      .wdata_i  (bus.cmd_wdata),
      .commit_i (do_commit),
      .shadow_o (shadow[g]),
      .active_o (active[g])
    );
    assign cfg_flat[g*DW +: DW] = active[g];
  end

  assign bus.rsp_valid = (state_q == RSP_FULL);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign commit_pend   = pend_q;
  assign commit_done   = done_q;

endmodule

// File: tb/tb_dsp_cfg_regfile.sv
// Self-checking bench for dsp_cfg_regfile with a transaction-level model.
module tb_dsp_cfg_regfile;
  localparam int DW   = 16;
  localparam int NREG = 37;
  localparam int AW   = 6;

  logic clk = 1'b0;
  logic reset;
  logic eng_busy;
  logic commit_pend, commit_done;
  logic [NREG*DW-1:0] cfg_flat;

  int n_checks = 0;
  int n_errors = 0;

  dsp_cfg_regfile_if #(.DW(DW), .AW(AW)) bus ();

  dsp_cfg_regfile #(.DW(DW), .NREG(NREG), .AW(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .eng_busy    (eng_busy),
    .commit_pend (commit_pend),
    .commit_done (commit_done),
    .cfg_flat    (cfg_flat)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [DW-1:0] m_sh [NREG];
  logic [DW-1:0] m_ac [NREG];
  logic          m_pend, m_done, m_rv, m_err;
  logic [DW-1:0] m_rdata;

  function automatic logic [NREG*DW-1:0] model_flat();
    logic [NREG*DW-1:0] r;
    for (int i = 0; i < NREG; i++) r[i*DW +: DW] = m_ac[i];
    return r;
  endfunction

  function automatic logic model_ready();
    return !reset && (!m_rv || bus.rsp_ready);
  endfunction

  task automatic drive(input logic v, input logic w, input int a,
                       input logic [DW-1:0] d, input logic [1:0] s);
    bus.cmd_valid = v;
    bus.cmd_write = w;
    bus.cmd_addr  = AW'(a);
    bus.cmd_wdata = d;
    bus.cmd_wstrb = s;
  endtask

  // Advance one clock, updating the model from the inputs present at the edge
  task automatic cycle();
    logic acc, cmt, req, er;
    logic [DW-1:0] rd;
    int a;
    a   = int'(bus.cmd_addr);
    acc = model_ready() && bus.cmd_valid;
    cmt = m_pend && !eng_busy;
    req = acc && bus.cmd_write && a == NREG && bus.cmd_wstrb[0] && bus.cmd_wdata[0];
    er  = a > NREG;
    rd  = '0;
    if (!bus.cmd_write) begin
      if (a < NREG) rd = m_sh[a];
      else if (a == NREG) rd = {{(DW-2){1'b0}}, eng_busy, m_pend};
    end
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin m_sh[i] = '0; m_ac[i] = '0; end
      m_pend = 0; m_done = 0; m_rv = 0; m_err = 0; m_rdata = '0;
    end else begin
      if (cmt) for (int i = 0; i < NREG; i++) m_ac[i] = m_sh[i];
      m_done = cmt;
      m_pend = (m_pend && !cmt) || req;
      if (acc) begin
        m_rv = 1; m_rdata = rd; m_err = er;
        if (bus.cmd_write && a < NREG)
          for (int b = 0; b < DW/8; b++)
            if (bus.cmd_wstrb[b]) m_sh[a][8*b +: 8] = bus.cmd_wdata[8*b +: 8];
      end else if (bus.rsp_ready) begin
        m_rv = 0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1; eng_busy = 0; bus.rsp_ready = 0;
    drive(0, 0, 0, '0, 2'b00);
    #1;
    n_checks++; if (bus.cmd_ready !== 1'b0) begin n_errors++; $display("FAIL reset_ready: got %b want 0", bus.cmd_ready); end
    cycle(); cycle();
    n_checks++; if (bus.rsp_valid !== 1'b0) begin n_errors++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
    n_checks++; if (bus.rsp_rdata !== '0 || bus.rsp_err !== 1'b0) begin n_errors++; $display("FAIL reset_rsp_data: got %h/%b want 0/0", bus.rsp_rdata, bus.rsp_err); end
    n_checks++; if (commit_pend !== 1'b0 || commit_done !== 1'b0) begin n_errors++; $display("FAIL reset_commit: got %b%b want 00", commit_pend, commit_done); end
    n_checks++; if (cfg_flat !== '0) begin n_errors++; $display("FAIL reset_flat: got %h want 0", cfg_flat); end
    reset = 0; bus.rsp_ready = 1;
  endtask

  task automatic test_write_read();
    drive(1, 1, 3, 16'hBEEF, 2'b11); #1; cycle();
    n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 16'h0 || bus.rsp_err !== 1'b0) begin n_errors++; $display("FAIL wr_rsp: got v=%b d=%h e=%b want 1/0000/0", bus.rsp_valid, bus.rsp_rdata, bus.rsp_err); end
    drive(1, 0, 3, '0, 2'b00); #1; cycle();
    n_checks++; if (bus.rsp_rdata !== 16'hBEEF || bus.rsp_err !== 1'b0) begin n_errors++; $display("FAIL rd_beef: got %h/%b want beef/0", bus.rsp_rdata, bus.rsp_err); end
    n_checks++; if (cfg_flat[3*DW +: DW] !== 16'h0) begin n_errors++; $display("FAIL active_before_commit: got %h want 0000", cfg_flat[3*DW +: DW]); end
    drive(1, 1, 3, 16'h1234, 2'b01); #1; cycle();
    drive(1, 0, 3, '0, 2'b00); #1; cycle();
    n_checks++; if (bus.rsp_rdata !== 16'hBE34) begin n_errors++; $display("FAIL rd_strobe: got %h want be34", bus.rsp_rdata); end
    drive(0, 0, 0, '0, 2'b00); #1; cycle();
  endtask

  task automatic test_commit();
    eng_busy = 1;
    drive(1, 1, NREG, 16'h0001, 2'b01); #1; cycle();
    drive(0, 0, 0, '0, 2'b00);
    for (int i = 0; i < 10; i++) begin
      cycle();
      n_checks++; if (commit_pend !== 1'b1 || commit_done !== 1'b0) begin n_errors++; $display("FAIL pend_hold[%0d]: got %b%b want 10", i, commit_pend, commit_done); end
    end
    eng_busy = 0; #1; cycle();
    n_checks++; if (commit_pend !== 1'b0 || commit_done !== 1'b1) begin n_errors++; $display("FAIL commit_edge: got %b%b want 01", commit_pend, commit_done); end
    n_checks++; if (cfg_flat[3*DW +: DW] !== 16'hBE34 || cfg_flat !== model_flat()) begin n_errors++; $display("FAIL commit_flat: got %h want %h", cfg_flat, model_flat()); end
    cycle();
    n_checks++; if (commit_done !== 1'b0) begin n_errors++; $display("FAIL done_pulse: got %b want 0", commit_done); end
    // earliest commit: the edge after the CTRL write
    drive(1, 1, NREG, 16'h0001, 2'b01); #1; cycle();
    n_checks++; if (commit_pend !== 1'b1) begin n_errors++; $display("FAIL pend_set: got %b want 1", commit_pend); end
    drive(0, 0, 0, '0, 2'b00); #1; cycle();
    n_checks++; if (commit_done !== 1'b1 || commit_pend !== 1'b0) begin n_errors++; $display("FAIL early_commit: got %b%b want 01", commit_pend, commit_done); end
  endtask

  task automatic test_back_to_back();
    drive(1, 0, 3, '0, 2'b00); #1; cycle();
    bus.rsp_ready = 0;
    drive(1, 1, 5, 16'hA5A5, 2'b11);
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++; if (bus.cmd_ready !== 1'b0) begin n_errors++; $display("FAIL bp_ready[%0d]: got %b want 0", i, bus.cmd_ready); end
      cycle();
      n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 16'hBE34) begin n_errors++; $display("FAIL bp_hold[%0d]: got v=%b d=%h want 1/be34", i, bus.rsp_valid, bus.rsp_rdata); end
    end
    bus.rsp_ready = 1; #1;
    n_checks++; if (bus.cmd_ready !== 1'b1) begin n_errors++; $display("FAIL bp_release: got %b want 1", bus.cmd_ready); end
    cycle();
    n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 16'h0) begin n_errors++; $display("FAIL bp_reload: got v=%b d=%h want 1/0000", bus.rsp_valid, bus.rsp_rdata); end
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, (i % 2) ? 5 : 3, '0, 2'b00); #1; cycle();
      n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== m_rdata) begin n_errors++; $display("FAIL b2b_rd[%0d]: got v=%b d=%h want 1/%h", i, bus.rsp_valid, bus.rsp_rdata, m_rdata); end
    end
    n_checks++; if (m_rdata !== 16'hA5A5) begin n_errors++; $display("FAIL b2b_last: got %h want a5a5", m_rdata); end
    drive(0, 0, 0, '0, 2'b00); #1; cycle();
    n_checks++; if (bus.rsp_valid !== 1'b0) begin n_errors++; $display("FAIL drain: got %b want 0", bus.rsp_valid); end
  endtask

  task automatic test_err_ctrl();
    drive(1, 0, NREG + 1, '0, 2'b00); #1; cycle();
    n_checks++; if (bus.rsp_err !== 1'b1 || bus.rsp_rdata !== 16'h0) begin n_errors++; $display("FAIL err_rd: got e=%b d=%h want 1/0000", bus.rsp_err, bus.rsp_rdata); end
    drive(1, 1, 63, 16'hFFFF, 2'b11); #1; cycle();
    n_checks++; if (bus.rsp_err !== 1'b1 || commit_pend !== 1'b0) begin n_errors++; $display("FAIL err_wr: got e=%b p=%b want 1/0", bus.rsp_err, commit_pend); end
    drive(1, 0, 3, '0, 2'b00); #1; cycle();
    n_checks++; if (bus.rsp_rdata !== 16'hBE34 || bus.rsp_err !== 1'b0) begin n_errors++; $display("FAIL err_nochange: got %h/%b want be34/0", bus.rsp_rdata, bus.rsp_err); end
    eng_busy = 1;
    drive(1, 1, NREG, 16'h0001, 2'b01); #1; cycle();
    drive(1, 0, NREG, '0, 2'b00); #1; cycle();
    n_checks++; if (bus.rsp_rdata !== 16'h0003 || bus.rsp_err !== 1'b0) begin n_errors++; $display("FAIL status_rd: got %h/%b want 0003/0", bus.rsp_rdata, bus.rsp_err); end
  endtask

  task automatic test_reset_mid();
    bus.rsp_ready = 0;
    drive(1, 0, 0, '0, 2'b00); #1; cycle();
    n_checks++; if (bus.rsp_valid !== 1'b1 || commit_pend !== 1'b1) begin n_errors++; $display("FAIL pre_reset: got v=%b p=%b want 1/1", bus.rsp_valid, commit_pend); end
    reset = 1; eng_busy = 0; drive(0, 0, 0, '0, 2'b00); #1; cycle();
    n_checks++; if (bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== '0 || bus.rsp_err !== 1'b0) begin n_errors++; $display("FAIL mid_reset_rsp: got v=%b d=%h e=%b want 0/0/0", bus.rsp_valid, bus.rsp_rdata, bus.rsp_err); end
    n_checks++; if (commit_pend !== 1'b0 || commit_done !== 1'b0 || cfg_flat !== '0) begin n_errors++; $display("FAIL mid_reset_state: got p=%b d=%b flat=%h want 0/0/0", commit_pend, commit_done, cfg_flat); end
    reset = 0; bus.rsp_ready = 1; #1; cycle();
    n_checks++; if (commit_done !== 1'b0 || commit_pend !== 1'b0) begin n_errors++; $display("FAIL post_reset: got p=%b d=%b want 0/0", commit_pend, commit_done); end
  endtask

  task automatic test_random();
    int a;
    for (int n = 0; n < 600; n++) begin
      reset    = ($urandom_range(0, 99) == 0);
      eng_busy = ($urandom_range(0, 2) == 0);
      bus.rsp_ready = ($urandom_range(0, 9) < 7);
      a = ($urandom_range(0, 7) == 0) ? 63 : int'($urandom_range(0, NREG + 2));
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, a,
            DW'($urandom), 2'($urandom_range(0, 3)));
      #1;
      n_checks++; if (bus.cmd_ready !== model_ready()) begin n_errors++; $display("FAIL rnd_ready[%0d]: got %b want %b", n, bus.cmd_ready, model_ready()); end
      cycle();
      n_checks++; if (bus.rsp_valid !== m_rv || bus.rsp_rdata !== m_rdata || bus.rsp_err !== m_err) begin n_errors++; $display("FAIL rnd_rsp[%0d]: got v=%b d=%h e=%b want %b/%h/%b", n, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, m_rv, m_rdata, m_err); end
      n_checks++; if (commit_pend !== m_pend || commit_done !== m_done) begin n_errors++; $display("FAIL rnd_commit[%0d]: got p=%b d=%b want %b/%b", n, commit_pend, commit_done, m_pend, m_done); end
      n_checks++; if (cfg_flat !== model_flat()) begin n_errors++; $display("FAIL rnd_flat[%0d]: got %h want %h", n, cfg_flat, model_flat()); end
    end
    reset = 0;
  endtask

  initial begin
    for (int i = 0; i < NREG; i++) begin m_sh[i] = '0; m_ac[i] = '0; end
    m_pend = 0; m_done = 0; m_rv = 0; m_err = 0; m_rdata = '0;
    test_reset();
    test_write_read();
    test_commit();
    test_back_to_back();
    test_err_ctrl();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
